o_ddr_tx_ctrl: RTL and testbench
================================

# o_ddr_tx_ctrl

Transmit sequencer that serializes parallel words into the 2-bit-per-cycle stream consumed by an O_DDR output register. It accepts words over a valid/ready handshake and emits one bit pair per clock on D. It drives the O_DDR enable E and optionally inserts a link-training pattern on request. It sits between fabric logic and an O_DDR instance, and both share clock C and reset R.

## Interface
Parameters:
- WIDTH, 8: parallel word width; even, ≥ 2; sent as WIDTH/2 bit pairs.
- TRAIN_CYCLES, 16: number of clock cycles in a training burst; ≥ 1.

Ports:
- C  input  1  clock; all state changes on posedge C.
- R  input  1  asynchronous, active-low reset.
- DIN  input  WIDTH  parallel data word.
- DIN_VALID  input  1  DIN holds a word to send.
- DIN_READY  output  1  block takes DIN on the next posedge where DIN_VALID=1.
- TRAIN_REQ  input  1  level request for a training burst.
- D  output  2  bit pair to O_DDR D[1:0]; D[0] is the first bit in time, D[1] the second.
- E  output  1  to O_DDR E; high while the line carries valid data or the training pattern.
- BUSY  output  1  high in SEND or TRAIN.
- TRAIN_DONE  output  1  one-cycle pulse when a training burst ends.

## Operation
- States: IDLE, SEND, TRAIN. A pair counter `cnt` is wide enough for max(WIDTH/2, TRAIN_CYCLES)−1.
- Reset (R=0, asynchronous): state=IDLE, D=2'b00, E=0, BUSY=0, TRAIN_DONE=0, DIN_READY=0, cnt=0. A word in flight is discarded.
- DIN_READY = 1 in IDLE when TRAIN_REQ=0, or in SEND when cnt=WIDTH/2−1 and TRAIN_REQ=0. It is 0 otherwise, including the first cycle after reset release.
- Accept (DIN_VALID & DIN_READY at posedge): the word is latched into a shift register. On that same edge D←DIN[1:0], E←1, state←SEND, cnt←0.
- SEND: on each edge cnt increments and D←pair cnt, where pair k = word[2k+1:2k]. After pair WIDTH/2−1:
  - If another word is accepted on that edge, its pair 0 is emitted with no gap.
  - Otherwise, if TRAIN_REQ=1, go to TRAIN.
  - Otherwise state←IDLE, D←2'b00, E←0.
- IDLE: if TRAIN_REQ=1, TRAIN is entered; TRAIN_REQ has priority over DIN_VALID. Otherwise hold D=2'b00 and E=0.
- TRAIN: D=2'b01 (line toggles 1,0 each half-cycle) and E=1 for exactly TRAIN_CYCLES edges. Then:
  - TRAIN_DONE=1 for one cycle.
  - Return to IDLE with D=2'b00 and E=0.
  - A new burst starts only after TRAIN_REQ is seen in IDLE again.
- TRAIN_REQ asserted during SEND is never lost while held. The current word completes, then TRAIN starts.
- DIN is sampled only on the accept edge. Changes to DIN mid-word have no effect.

## Timing
- All outputs are registered. No combinational path from inputs to D, E, BUSY or TRAIN_DONE.
- DIN_READY is combinational from state, cnt and TRAIN_REQ only. It has no dependence on DIN_VALID.
- Latency: a word accepted at edge t presents pair k on D after edge t+k. The word occupies exactly WIDTH/2 cycles.
- Continuous DIN_VALID=1 gives 100% line utilization: one word per WIDTH/2 cycles.
- BUSY=1 from the edge that enters SEND or TRAIN until the edge that returns to IDLE.
- TRAIN_DONE is asserted in the cycle after the last training pair, coincident with IDLE.

## Configuration
- O_DDR_TX_CTRL_TRAIN_EN defined: TRAIN state, TRAIN_REQ handling and TRAIN_DONE behave as above.
- O_DDR_TX_CTRL_TRAIN_EN not defined:
  - TRAIN is not built and TRAIN_REQ is ignored.
  - DIN_READY does not depend on TRAIN_REQ.
  - TRAIN_DONE is tied to 0.
  - TRAIN_CYCLES is unused.

## Test plan
- Reset, then DIN=8'hB4 with valid for one cycle (WIDTH=8) → D = 00, 01, 11, 10 on the four following cycles with E=1. Then D=00, E=0, BUSY=0.
- Back-to-back 8'hFF, 8'h00 with DIN_VALID held → D = 11×4 then 00×4, E=1 throughout, DIN_READY high only on the last pair of each word.
- TRAIN_REQ=1 and DIN_VALID=1 together in IDLE (macro defined, TRAIN_CYCLES=16) → D=01 for 16 cycles, then TRAIN_DONE pulses for 1 cycle, then the word is accepted.
- TRAIN_REQ raised mid-word → word completes intact, then training starts with no IDLE cycle between them.
- R asserted on the second pair of a word → D=00, E=0, BUSY=0 immediately, without waiting for a clock edge. After release, DIN_READY=0 for one cycle and the old word is never resumed.
- Macro undefined, TRAIN_REQ held high → words stream normally and TRAIN_DONE stays 0.

Source files
------------

// File: rtl/o_ddr_tx_ctrl.sv
// Serializes parallel words into 2-bit pairs for an O_DDR output register, with optional link training.
// Optional training burst support is built when O_DDR_TX_CTRL_TRAIN_EN is defined.
module o_ddr_tx_ctrl #(
    parameter int WIDTH        = 8,
    parameter int TRAIN_CYCLES = 16
) (
    input  logic             C,
    input  logic             R,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DIN_VALID,
    output logic             DIN_READY,
    input  logic             TRAIN_REQ,
    output logic [1:0]       D,
    output logic             E,
    output logic             BUSY,
    output logic             TRAIN_DONE
);

    localparam int PAIRS = WIDTH / 2;
    localparam int MAXC  = (PAIRS > TRAIN_CYCLES) ? PAIRS : TRAIN_CYCLES;
    localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] LAST_PAIR = CW'(PAIRS - 1);
`ifdef O_DDR_TX_CTRL_TRAIN_EN
    localparam logic [CW-1:0] LAST_TRAIN = CW'(TRAIN_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1
`ifdef O_DDR_TX_CTRL_TRAIN_EN
        ,
        S_TRAIN = 2'd2
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [1:0]       d_q, d_d;
    logic             e_q, e_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rdy_en_q;
    logic             treq;
    logic             accept;

`ifdef O_DDR_TX_CTRL_TRAIN_EN
    assign treq = TRAIN_REQ;
`else
    logic unused_train_req;
    assign unused_train_req = TRAIN_REQ;
    assign treq = 1'b0;
`endif

    // Ready is held off for the first cycle after reset release so no word slips in mid-release.
    always_comb begin
        DIN_READY = rdy_en_q & ~treq &
                    ((state_q == S_IDLE) | ((state_q == S_SEND) & (cnt_q == LAST_PAIR)));
    end

    assign accept = DIN_READY & DIN_VALID;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        d_d     = 2'b00;
        e_d     = 1'b0;
        done_d  = 1'b0;
        if (accept) begin
            state_d = S_SEND;
            cnt_d   = '0;
            shreg_d = DIN >> 2;
            d_d     = DIN[1:0];
            e_d     = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
`ifdef O_DDR_TX_CTRL_TRAIN_EN
                    if (treq) begin
                        state_d = S_TRAIN;
                        cnt_d   = '0;
                        d_d     = 2'b01;
                        e_d     = 1'b1;
                    end
`endif
                end
                S_SEND: begin
                    if (cnt_q == LAST_PAIR) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
`ifdef O_DDR_TX_CTRL_TRAIN_EN
                        // A request held during the word starts training right after its last pair.
                        if (treq) begin
                            state_d = S_TRAIN;
                            d_d     = 2'b01;
                            e_d     = 1'b1;
                        end
`endif
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        d_d     = shreg_q[1:0];
                        shreg_d = shreg_q >> 2;
                        e_d     = 1'b1;
                    end
                end
`ifdef O_DDR_TX_CTRL_TRAIN_EN
                S_TRAIN: begin
                    if (cnt_q == LAST_TRAIN) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        d_d   = 2'b01;
                        e_d   = 1'b1;
                    end
                end
`endif
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            d_q      <= 2'b00;
            e_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            d_q      <= d_d;
            e_q      <= e_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rdy_en_q <= 1'b1;
        end
    end

    assign D          = d_q;
    assign E          = e_q;
    assign BUSY       = busy_q;
    assign TRAIN_DONE = done_q;

endmodule

// File: tb/tb_o_ddr_tx_ctrl.sv
// Directed self-checking bench for o_ddr_tx_ctrl (WIDTH=8, TRAIN_CYCLES=16).
// Training scenarios run when O_DDR_TX_CTRL_TRAIN_EN is defined; otherwise TRAIN_REQ must be ignored.
module tb_o_ddr_tx_ctrl;

    logic       C;
    logic       R;
    logic [7:0] DIN;
    logic       DIN_VALID;
    logic       DIN_READY;
    logic       TRAIN_REQ;
    logic [1:0] D;
    logic       E;
    logic       BUSY;
    logic       TRAIN_DONE;

    int checkCount = 0;
    int errorCount = 0;

    logic [1:0] pairsB4 [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [1:0] pairsC3 [4] = '{2'b11, 2'b00, 2'b00, 2'b11};
    logic [1:0] pairs9C [4] = '{2'b00, 2'b11, 2'b01, 2'b10};

    o_ddr_tx_ctrl #(.WIDTH(8), .TRAIN_CYCLES(16)) dut (
        .C          (C),
        .R          (R),
        .DIN        (DIN),
        .DIN_VALID  (DIN_VALID),
        .DIN_READY  (DIN_READY),
        .TRAIN_REQ  (TRAIN_REQ),
        .D          (D),
        .E          (E),
        .BUSY       (BUSY),
        .TRAIN_DONE (TRAIN_DONE)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] din, input logic valid, input logic treq);
        DIN       = din;
        DIN_VALID = valid;
        TRAIN_REQ = treq;
    endtask

    // Advance one edge and settle just after it, away from the active edge.
    task automatic tick();
        @(posedge C);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        R = 1'b0;
        applyStimulus(8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge C);
        #1;
        checkOutput("rst_d", {6'b0, D}, 8'h0);
        checkOutput("rst_e", {7'b0, E}, 8'h0);
        checkOutput("rst_busy", {7'b0, BUSY}, 8'h0);
        checkOutput("rst_done", {7'b0, TRAIN_DONE}, 8'h0);
        checkOutput("rst_ready", {7'b0, DIN_READY}, 8'h0);
        R = 1'b1;
        checkOutput("rel_ready", {7'b0, DIN_READY}, 8'h0);
        tick();
        checkOutput("idle_ready", {7'b0, DIN_READY}, 8'h1);

        // Single word, DIN changed right after accept must not matter.
        applyStimulus(8'hB4, 1'b1, 1'b0);
        tick();
        applyStimulus(8'h5A, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("b4_d%0d", k), {6'b0, D}, {6'b0, pairsB4[k]});
            checkOutput($sformatf("b4_e%0d", k), {7'b0, E}, 8'h1);
            checkOutput($sformatf("b4_busy%0d", k), {7'b0, BUSY}, 8'h1);
            checkOutput($sformatf("b4_rdy%0d", k), {7'b0, DIN_READY}, (k == 3) ? 8'h1 : 8'h0);
            tick();
        end
        checkOutput("b4_end_d", {6'b0, D}, 8'h0);
        checkOutput("b4_end_e", {7'b0, E}, 8'h0);
        checkOutput("b4_end_busy", {7'b0, BUSY}, 8'h0);

        // Back-to-back FF then 00 with valid held.
        applyStimulus(8'hFF, 1'b1, 1'b0);
        tick();
        applyStimulus(8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("b2b_d%0d", i), {6'b0, D}, (i < 4) ? 8'h3 : 8'h0);
            checkOutput($sformatf("b2b_e%0d", i), {7'b0, E}, 8'h1);
            checkOutput($sformatf("b2b_rdy%0d", i), {7'b0, DIN_READY}, ((i % 4) == 3) ? 8'h1 : 8'h0);
            if (i == 7) DIN_VALID = 1'b0;
            tick();
        end
        checkOutput("b2b_end_e", {7'b0, E}, 8'h0);
        checkOutput("b2b_end_busy", {7'b0, BUSY}, 8'h0);

        // Asynchronous reset on the second pair of a word.
        applyStimulus(8'h1B, 1'b1, 1'b0);
        tick();
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("mw_p0", {6'b0, D}, 8'h3);
        tick();
        checkOutput("mw_p1", {6'b0, D}, 8'h2);
        #2;
        R = 1'b0;
        #1;
        checkOutput("arst_d", {6'b0, D}, 8'h0);
        checkOutput("arst_e", {7'b0, E}, 8'h0);
        checkOutput("arst_busy", {7'b0, BUSY}, 8'h0);
        checkOutput("arst_ready", {7'b0, DIN_READY}, 8'h0);
        tick();
        R = 1'b1;
        checkOutput("arel_ready", {7'b0, DIN_READY}, 8'h0);
        tick();
        checkOutput("arel_d", {6'b0, D}, 8'h0);
        checkOutput("arel_e", {7'b0, E}, 8'h0);
        checkOutput("arel_ready1", {7'b0, DIN_READY}, 8'h1);
        tick();
        checkOutput("arel_d2", {6'b0, D}, 8'h0);
        checkOutput("arel_busy2", {7'b0, BUSY}, 8'h0);

`ifdef O_DDR_TX_CTRL_TRAIN_EN
        // Training request and valid together in IDLE: training wins, word follows.
        applyStimulus(8'hC3, 1'b1, 1'b1);
        checkOutput("trq_ready", {7'b0, DIN_READY}, 8'h0);
        tick();
        applyStimulus(8'hC3, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("tr_d%0d", i), {6'b0, D}, 8'h1);
            checkOutput($sformatf("tr_e%0d", i), {7'b0, E}, 8'h1);
            checkOutput($sformatf("tr_busy%0d", i), {7'b0, BUSY}, 8'h1);
            checkOutput($sformatf("tr_done%0d", i), {7'b0, TRAIN_DONE}, 8'h0);
            checkOutput($sformatf("tr_rdy%0d", i), {7'b0, DIN_READY}, 8'h0);
            tick();
        end
        checkOutput("tr_done", {7'b0, TRAIN_DONE}, 8'h1);
        checkOutput("tr_end_d", {6'b0, D}, 8'h0);
        checkOutput("tr_end_e", {7'b0, E}, 8'h0);
        checkOutput("tr_end_busy", {7'b0, BUSY}, 8'h0);
        checkOutput("tr_end_rdy", {7'b0, DIN_READY}, 8'h1);
        tick();
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("tr_done_low", {7'b0, TRAIN_DONE}, 8'h0);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("c3_d%0d", k), {6'b0, D}, {6'b0, pairsC3[k]});
            tick();
        end
        checkOutput("c3_end_e", {7'b0, E}, 8'h0);

        // Training requested mid-word: word completes, training follows with no gap.
        applyStimulus(8'h9C, 1'b1, 1'b0);
        tick();
        applyStimulus(8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("9c_d%0d", k), {6'b0, D}, {6'b0, pairs9C[k]});
            checkOutput($sformatf("9c_e%0d", k), {7'b0, E}, 8'h1);
            if (k == 3) checkOutput("9c_rdy3", {7'b0, DIN_READY}, 8'h0);
            if (k == 1) TRAIN_REQ = 1'b1;
            tick();
        end
        TRAIN_REQ = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("mtr_d%0d", i), {6'b0, D}, 8'h1);
            checkOutput($sformatf("mtr_e%0d", i), {7'b0, E}, 8'h1);
            checkOutput($sformatf("mtr_busy%0d", i), {7'b0, BUSY}, 8'h1);
            tick();
        end
        checkOutput("mtr_done", {7'b0, TRAIN_DONE}, 8'h1);
        checkOutput("mtr_end_busy", {7'b0, BUSY}, 8'h0);
        tick();
        checkOutput("mtr_done_low", {7'b0, TRAIN_DONE}, 8'h0);
        checkOutput("mtr_idle_e", {7'b0, E}, 8'h0);
`else
        // Without training support, a held request must not disturb streaming.
        applyStimulus(8'hB4, 1'b1, 1'b1);
        checkOutput("nt_ready", {7'b0, DIN_READY}, 8'h1);
        tick();
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("nt_d%0d", i), {6'b0, D}, {6'b0, pairsB4[i % 4]});
            checkOutput($sformatf("nt_e%0d", i), {7'b0, E}, 8'h1);
            checkOutput($sformatf("nt_done%0d", i), {7'b0, TRAIN_DONE}, 8'h0);
            checkOutput($sformatf("nt_rdy%0d", i), {7'b0, DIN_READY}, ((i % 4) == 3) ? 8'h1 : 8'h0);
            if (i == 7) DIN_VALID = 1'b0;
            tick();
        end
        checkOutput("nt_end_e", {7'b0, E}, 8'h0);
        checkOutput("nt_end_busy", {7'b0, BUSY}, 8'h0);
        tick();
        checkOutput("nt_idle_done", {7'b0, TRAIN_DONE}, 8'h0);
        checkOutput("nt_idle_d", {6'b0, D}, 8'h0);
        TRAIN_REQ = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", checkCount, errorCount);
        $finish;
    end

endmodule
